// File: rtl/fifo_chain_driver_if.sv
// Handshake bundle between the chain driver and the two-stage FIFO chain (f0 -> f1).
// Flags and data_out come from the chain; push/pop/data_in/start go to it.
interface fifo_chain_driver_if #(
   parameter int WIDTH = 8
);
   logic             push;
   logic [1:0]       pop;
   logic [WIDTH-1:0] data_in;
   logic             start;
   logic [1:0]       empty;
   logic [1:0]       full;
   logic [WIDTH-1:0] data_out;

   modport master (
      output push, pop, data_in, start,
      input  empty, full, data_out
   );

   modport slave (
      input  push, pop, data_in, start,
      output empty, full, data_out
   );
endinterface

// File: rtl/fifo_chain_driver.sv
// Burst traffic generator and in-order checker for the f0 -> f1 FIFO chain.
// Pushes COUNT indexed words into f0, keeps the chain moving, and checks f1's output order.
//
// state | meaning
// IDLE  | waiting for go; counters and err hold their last values
// RUN   | pushing words into f0 while the chain drains
// DRAIN | all words sent; popping until COUNT words have left f1
// DONE  | one-cycle completion pulse, then back to IDLE
module fifo_chain_driver #(
   parameter int               WIDTH   = 8,
   parameter int               COUNT   = 16,
   parameter int               TAG_IDX = 3,
   parameter logic [WIDTH-1:0] SEED    = WIDTH'(8'hA5),
   localparam int              CW      = $clog2(COUNT + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                go,
   input  logic [2:0]          hold,
   fifo_chain_driver_if.master chain,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [CW-1:0]       sent_cnt,
   output logic [CW-1:0]       recv_cnt
);

   localparam int            XW      = (CW > WIDTH) ? CW : WIDTH;
   localparam logic [CW-1:0] COUNT_C = CW'(COUNT);
   localparam logic [CW-1:0] TAG_C   = CW'(TAG_IDX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic             active;
   logic             push_w;
   logic             pop0_w;
   logic             pop1_w;
   logic [XW-1:0]    sent_ext;
   logic [XW-1:0]    recv_ext;
   logic [WIDTH-1:0] exp_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (go) state_nxt = RUN;
         RUN:     if (sent_cnt == COUNT_C) state_nxt = DRAIN;
         DRAIN:   if (recv_cnt == COUNT_C) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // f0->f1 moves only on f1 room seen this cycle; no credit for a simultaneous f1 pop.
   always_comb begin
      active   = (state == RUN) || (state == DRAIN);
      push_w   = (state == RUN) && (sent_cnt < COUNT_C) && !chain.full[0] && !hold[0];
      pop0_w   = active && !chain.empty[0] && !chain.full[1] && !hold[1];
      pop1_w   = active && !chain.empty[1] && !hold[2];
      sent_ext = XW'(sent_cnt);
      recv_ext = XW'(recv_cnt);
      exp_data = recv_ext[WIDTH-1:0] ^ SEED;
   end

   always_comb begin
      chain.push    = push_w;
      chain.pop     = {pop1_w, pop0_w};
      chain.data_in = sent_ext[WIDTH-1:0] ^ SEED;
      chain.start   = push_w && (sent_cnt == TAG_C);
      busy          = active;
      done          = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sent_cnt <= '0;
         recv_cnt <= '0;
         err      <= 1'b0;
      end else if ((state == IDLE) && go) begin
         sent_cnt <= '0;
         recv_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (push_w) begin
            sent_cnt <= sent_cnt + CW'(1);
         end
         if (pop1_w && (recv_cnt < COUNT_C)) begin
            recv_cnt <= recv_cnt + CW'(1);
         end
         if (pop1_w && (chain.data_out != exp_data)) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_chain_driver.sv
// Bench for fifo_chain_driver: two drivers (COUNT=16/TAG=3 and COUNT=1/TAG=0), each on a
// behavioural depth-4 FWFT FIFO chain; chain A flags can be overridden for handshake vectors.
module tb_fifo_chain_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- chain A: COUNT=16, TAG_IDX=3 ----------------
   fifo_chain_driver_if #(.WIDTH(8)) ifa ();
   logic       go_a = 1'b0;
   logic [2:0] hold_a = 3'b111;
   logic       busy_a, done_a, err_a;
   logic [4:0] sent_a, recv_a;

   fifo_chain_driver #(.WIDTH(8), .COUNT(16), .TAG_IDX(3), .SEED(8'hA5)) dut_a (
      .clk(clk), .rst_n(rst_n), .go(go_a), .hold(hold_a), .chain(ifa),
      .busy(busy_a), .done(done_a), .err(err_a), .sent_cnt(sent_a), .recv_cnt(recv_a)
   );

   logic       ovr = 1'b0;
   logic [1:0] ovr_e = 2'b00;
   logic [1:0] ovr_f = 2'b00;
   logic       corrupt_a = 1'b0;
   logic [7:0] m0a [4];
   logic [7:0] m1a [4];
   logic [1:0] w0a, r0a, w1a, r1a;
   logic [2:0] c0a, c1a;
   int         pc_a;
   int         viol_a = 0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w0a <= '0; r0a <= '0; w1a <= '0; r1a <= '0; c0a <= '0; c1a <= '0; pc_a <= 0;
      end else if (!ovr) begin
         if (ifa.push) begin m0a[w0a] <= ifa.data_in; w0a <= w0a + 2'd1; end
         if (ifa.pop[0]) begin m1a[w1a] <= m0a[r0a]; r0a <= r0a + 2'd1; w1a <= w1a + 2'd1; end
         if (ifa.pop[1]) r1a <= r1a + 2'd1;
         c0a <= c0a + {2'b00, ifa.push} - {2'b00, ifa.pop[0]};
         c1a <= c1a + {2'b00, ifa.pop[0]} - {2'b00, ifa.pop[1]};
         if (go_a) pc_a <= 0;
         else if (ifa.pop[1]) pc_a <= pc_a + 1;
      end
   end

   assign ifa.empty    = ovr ? ovr_e : {c1a == 3'd0, c0a == 3'd0};
   assign ifa.full     = ovr ? ovr_f : {c1a == 3'd4, c0a == 3'd4};
   assign ifa.data_out = m1a[r1a] ^ ((corrupt_a && pc_a == 4) ? 8'h01 : 8'h00);

   always @(posedge clk) begin
      if ((ifa.push && (ifa.full[0] || hold_a[0])) ||
          (ifa.pop[0] && (ifa.empty[0] || ifa.full[1] || hold_a[1])) ||
          (ifa.pop[1] && (ifa.empty[1] || hold_a[2])) ||
          ((ifa.push || ifa.pop != 2'b00 || ifa.start) && !busy_a))
         viol_a <= viol_a + 1;
   end

   // ---------------- chain B: COUNT=1, TAG_IDX=0 ----------------
   fifo_chain_driver_if #(.WIDTH(8)) ifb ();
   logic       go_b = 1'b0;
   logic [2:0] hold_b = 3'b000;
   logic       busy_b, done_b, err_b;
   logic [0:0] sent_b, recv_b;

   fifo_chain_driver #(.WIDTH(8), .COUNT(1), .TAG_IDX(0), .SEED(8'hA5)) dut_b (
      .clk(clk), .rst_n(rst_n), .go(go_b), .hold(hold_b), .chain(ifb),
      .busy(busy_b), .done(done_b), .err(err_b), .sent_cnt(sent_b), .recv_cnt(recv_b)
   );

   logic [7:0] m0b [4];
   logic [7:0] m1b [4];
   logic [1:0] w0b, r0b, w1b, r1b;
   logic [2:0] c0b, c1b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w0b <= '0; r0b <= '0; w1b <= '0; r1b <= '0; c0b <= '0; c1b <= '0;
      end else begin
         if (ifb.push) begin m0b[w0b] <= ifb.data_in; w0b <= w0b + 2'd1; end
         if (ifb.pop[0]) begin m1b[w1b] <= m0b[r0b]; r0b <= r0b + 2'd1; w1b <= w1b + 2'd1; end
         if (ifb.pop[1]) r1b <= r1b + 2'd1;
         c0b <= c0b + {2'b00, ifb.push} - {2'b00, ifb.pop[0]};
         c1b <= c1b + {2'b00, ifb.pop[0]} - {2'b00, ifb.pop[1]};
      end
   end

   assign ifb.empty    = {c1b == 3'd0, c0b == 3'd0};
   assign ifb.full     = {c1b == 3'd4, c0b == 3'd4};
   assign ifb.data_out = m1b[r1b];

   // ---------------- stimulus helpers ----------------
   typedef struct {
      logic [2:0] hold;
      logic [1:0] empty;
      logic [1:0] full;
      logic       exp_push;
      logic [1:0] exp_pop;
   } vec_t;

   vec_t vecs [12];

   function automatic logic [2:0] pick(input int mode, input bit rel);
      case (mode)
         1:       return rel ? 3'b000 : 3'b100;
         2:       return 3'($urandom_range(0, 7));
         default: return 3'b000;
      endcase
   endfunction

   // Runs chain A from the first cycle after go until done, checking every push and err.
   task automatic run_a(input int mode, output int cyc);
      int         k = 0;
      int         pops = 0;
      bit         rel = 1'b0;
      bit         seen = 1'b0;
      logic [7:0] kb;
      cyc = 0;
      while (!seen && cyc < 1000) begin
         @(negedge clk);
         if (ifa.full == 2'b11) rel = 1'b1;
         hold_a = pick(mode, rel);
         #1;
         if (ifa.push) begin
            kb = 8'(k);
            chk("data_in", 32'(ifa.data_in), 32'(kb ^ 8'hA5));
            chk("start", 32'(ifa.start), 32'(k == 3));
            k++;
         end
         if (ifa.pop[1]) pops++;
         @(posedge clk);
         #1;
         cyc++;
         chk("err_track", 32'(err_a), 32'(mode == 3 && pops >= 5));
         if (done_a) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("push_total", 32'(k), 32'd16);
      chk("pop_total", 32'(pops), 32'd16);
      chk("busy_at_done", 32'(busy_a), 32'd0);
      chk("recv_cnt", 32'(recv_a), 32'd16);
      chk("sent_cnt", 32'(sent_a), 32'd16);
      chk("no_violation", 32'(viol_a), 32'd0);
      if (mode == 1) chk("both_full_reached", 32'(rel), 32'd1);
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(done_a), 32'd0);
      chk("err_after_done", 32'(err_a), 32'(mode == 3));
   endtask

   task automatic burst_a(input int mode);
      int cyc;
      @(negedge clk);
      hold_a = pick(mode, 1'b0);
      go_a   = 1'b1;
      @(posedge clk);
      #1;
      go_a = 1'b0;
      chk("busy_after_go", 32'(busy_a), 32'd1);
      chk("err_cleared_by_go", 32'(err_a), 32'd0);
      chk("sent_cleared_by_go", 32'(sent_a), 32'd0);
      run_a(mode, cyc);
      if (mode == 0) chk("burst_cycles", 32'(cyc), 32'd19);
   endtask

   task automatic check_reset_a(input string tag);
      chk({tag, "_push"},    32'(ifa.push),    32'd0);
      chk({tag, "_pop"},     32'(ifa.pop),     32'd0);
      chk({tag, "_start"},   32'(ifa.start),   32'd0);
      chk({tag, "_busy"},    32'(busy_a),      32'd0);
      chk({tag, "_done"},    32'(done_a),      32'd0);
      chk({tag, "_err"},     32'(err_a),       32'd0);
      chk({tag, "_sent"},    32'(sent_a),      32'd0);
      chk({tag, "_recv"},    32'(recv_a),      32'd0);
      chk({tag, "_data_in"}, 32'(ifa.data_in), 32'h0A5);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int total;
      int cyc;

      vecs[0]  = '{hold: 3'b000, empty: 2'b11, full: 2'b00, exp_push: 1'b1, exp_pop: 2'b00};
      vecs[1]  = '{hold: 3'b000, empty: 2'b00, full: 2'b00, exp_push: 1'b1, exp_pop: 2'b11};
      vecs[2]  = '{hold: 3'b000, empty: 2'b00, full: 2'b11, exp_push: 1'b0, exp_pop: 2'b10};
      vecs[3]  = '{hold: 3'b000, empty: 2'b00, full: 2'b01, exp_push: 1'b0, exp_pop: 2'b11};
      vecs[4]  = '{hold: 3'b000, empty: 2'b00, full: 2'b10, exp_push: 1'b1, exp_pop: 2'b10};
      vecs[5]  = '{hold: 3'b001, empty: 2'b00, full: 2'b00, exp_push: 1'b0, exp_pop: 2'b11};
      vecs[6]  = '{hold: 3'b010, empty: 2'b00, full: 2'b00, exp_push: 1'b1, exp_pop: 2'b10};
      vecs[7]  = '{hold: 3'b100, empty: 2'b00, full: 2'b00, exp_push: 1'b1, exp_pop: 2'b01};
      vecs[8]  = '{hold: 3'b111, empty: 2'b00, full: 2'b00, exp_push: 1'b0, exp_pop: 2'b00};
      vecs[9]  = '{hold: 3'b000, empty: 2'b01, full: 2'b00, exp_push: 1'b1, exp_pop: 2'b10};
      vecs[10] = '{hold: 3'b000, empty: 2'b10, full: 2'b00, exp_push: 1'b1, exp_pop: 2'b01};
      vecs[11] = '{hold: 3'b011, empty: 2'b00, full: 2'b10, exp_push: 1'b0, exp_pop: 2'b10};

      #2 rst_n = 1'b0;
      #20;
      check_reset_a("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Frozen RUN state (hold=111) with overridden flags: combinational handshake vectors.
      @(negedge clk);
      hold_a = 3'b111;
      go_a   = 1'b1;
      @(posedge clk);
      #1;
      go_a = 1'b0;
      chk("frozen_busy", 32'(busy_a), 32'd1);
      ovr = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         hold_a = vecs[i].hold;
         ovr_e  = vecs[i].empty;
         ovr_f  = vecs[i].full;
         #1;
         chk($sformatf("vec%0d_push", i), 32'(ifa.push), 32'(vecs[i].exp_push));
         chk($sformatf("vec%0d_pop", i), 32'(ifa.pop), 32'(vecs[i].exp_pop));
         chk($sformatf("vec%0d_start", i), 32'(ifa.start), 32'd0);
         chk($sformatf("vec%0d_data_in", i), 32'(ifa.data_in), 32'h0A5);
         #1 hold_a = 3'b111;
      end
      @(negedge clk);
      ovr = 1'b0;
      chk("frozen_sent", 32'(sent_a), 32'd0);
      run_a(0, cyc);

      // Free run, fill backpressure, corruption, then a clean burst clearing err.
      burst_a(0);
      burst_a(1);
      corrupt_a = 1'b1;
      burst_a(3);
      corrupt_a = 1'b0;
      burst_a(0);

      // Reset mid-burst once sent_cnt reaches 7.
      @(negedge clk);
      hold_a = 3'b000;
      go_a   = 1'b1;
      @(posedge clk);
      #1;
      go_a = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      chk("midburst_sent", 32'(sent_a), 32'd7);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_a("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      burst_a(0);

      // COUNT=1 / TAG_IDX=0 driver with go held high while busy.
      @(negedge clk);
      go_b = 1'b1;
      @(posedge clk);
      #1;
      chk("b_busy", 32'(busy_b), 32'd1);
      chk("b_push", 32'(ifb.push), 32'd1);
      chk("b_start", 32'(ifb.start), 32'd1);
      chk("b_data_in", 32'(ifb.data_in), 32'h0A5);
      cyc = 0;
      @(posedge clk);
      #1;
      cyc = 1;
      chk("b_sent_after_push", 32'(sent_b), 32'd1);
      chk("b_no_second_push", 32'(ifb.push), 32'd0);
      @(negedge clk);
      go_b = 1'b0;
      while (!done_b && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("b_done_latency", 32'(cyc), 32'd4);
      chk("b_busy_at_done", 32'(busy_b), 32'd0);
      chk("b_recv", 32'(recv_b), 32'd1);
      chk("b_err", 32'(err_b), 32'd0);
      @(posedge clk);
      #1;
      chk("b_done_one_cycle", 32'(done_b), 32'd0);
      chk("b_no_restart", 32'(busy_b), 32'd0);

      // Random backpressure over repeated bursts.
      total = 0;
      while (total < 2000) begin
         int t0;
         t0 = $time / 10;
         burst_a(2);
         total += ($time / 10) - t0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_chain_driver.md
# fifo_chain_driver

Traffic generator and in-order checker for the two-stage FIFO chain: `f0` feeds `f1` on `pop[0]`, and `f1` is drained by `pop[1]`. It drives the chain's `push`, `pop[1:0]`, `data_in` and scoreboard `start` strobes, and it never violates a full/empty handshake. It counts the words popped from `f1` and compares each one against the expected sequence. It replaces hand-written formal assumptions with a synthesizable stimulus source for simulation and bring-up.

## Interface
- `WIDTH`, default 8: data width; must match the chain's FIFO data width.
- `COUNT`, default 16: words per burst; legal range 1..2^WIDTH.
- `TAG_IDX`, default 3: index of the word marked with `start`; must be less than `COUNT`.
- `SEED`, default 8'hA5: XOR mask applied to the word index to form the data value.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low; all state is cleared immediately on assertion.
- `go`  in  1  starts a burst; sampled in IDLE only.
- `hold`  in  3  backpressure: bit 0 blocks `push`, bit 1 blocks `pop[0]`, bit 2 blocks `pop[1]`.
- `empty`  in  2  FIFO empty flags `{f1, f0}`.
- `full`  in  2  FIFO full flags `{f1, f0}`.
- `data_out`  in  WIDTH  head of `f1`; first-word-fall-through, valid whenever `!empty[1]`.
- `push`  out  1  push into `f0`.
- `pop`  out  2  bit 0 moves `f0` to `f1`; bit 1 pops `f1`.
- `data_in`  out  WIDTH  word written to `f0`.
- `start`  out  1  one-cycle strobe, coincident with the `push` of word `TAG_IDX`.
- `busy`  out  1  high while in RUN or DRAIN.
- `done`  out  1  one-cycle pulse in the DONE state.
- `err`  out  1  sticky mismatch flag, cleared on the next `go`.
- `sent_cnt`  out  `$clog2(COUNT+1)`  number of words pushed.
- `recv_cnt`  out  `$clog2(COUNT+1)`  number of words popped from `f1`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN: on `go`. Both counters and `err` clear on the same edge.
  - RUN to DRAIN: when `sent_cnt == COUNT`.
  - DRAIN to DONE: when `recv_cnt == COUNT`.
  - DONE to IDLE: unconditionally, after one cycle.
- All outputs are combinational from registered state plus inputs. Outside RUN/DRAIN, `push`, `pop` and `start` are 0.
- `push = (state==RUN) && sent_cnt<COUNT && !full[0] && !hold[0]`.
- `pop[0] = !empty[0] && !full[1] && !hold[1]`.
- `pop[1] = !empty[1] && !hold[2]`.
- `data_in = sent_cnt[WIDTH-1:0] ^ SEED`. The index is truncated to `WIDTH` bits.
- `start = push && sent_cnt==TAG_IDX`.
- On each `pop[1]`, compare `data_out` with `recv_cnt[WIDTH-1:0] ^ SEED`. On mismatch, set `err`; it stays set until the next `go`.
- `sent_cnt` increments on `push` and `recv_cnt` increments on `pop[1]`. Both saturate at `COUNT` and never wrap.
- Simultaneous events are legal in one cycle:
  - `push`, `pop[0]` and `pop[1]` may all fire together.
  - `pop[0]` while `f1` pops is allowed only if `!full[1]` was seen that cycle; no pass-through credit is taken.
- Pops continue during RUN, so the chain drains concurrently with filling.
- `go` while `busy` is ignored.

## Timing
- Reset values: state IDLE; `push`, `pop`, `start`, `busy`, `done`, `err` = 0; `sent_cnt`, `recv_cnt` = 0; `data_in = SEED`.
- Cycle after `go`: `busy` = 1, and the first `push` may occur if `!full[0]`.
- Minimum latency from word k's push to its `pop[1]` is 2 cycles: push at cycle t, `pop[0]` at t+1, `pop[1]` at t+2.
- Minimum burst length with no backpressure is COUNT+3 cycles from `go` to `done`.
- `done` is high for exactly one cycle, and `busy` is 0 in that cycle.
- `rst_n` asserted mid-burst: outputs return to reset values asynchronously and the burst is abandoned. Words already in the FIFOs are not tracked.
- Holding `hold` = 3'b111 indefinitely freezes all counters. There is no timeout.

## Test plan
- Free-run, COUNT=16, `hold`=0: `go` pulse → 16 pushes with `data_in` A5,A4,A7,…; `start` on the 4th push (data A6); `done` pulse; `recv_cnt`=16, `err`=0.
- Fill backpressure, `hold[2]`=1 until both FIFOs report full, then release: `push` never asserts with `full[0]`, `pop[0]` never with `full[1]` → completes with `err`=0, `recv_cnt`=16.
- Corrupt `data_out` of the 5th popped word (XOR 8'h01) → `err` rises on that `pop[1]` and stays high through `done`. The next `go` clears it.
- Random `hold` every cycle for 2000 cycles over repeated bursts → no push/pop handshake violation; every burst ends with `done`, `err`=0.
- `rst_n` low for 1 cycle while `sent_cnt`=7 → all outputs at reset values within the same cycle; a subsequent `go` restarts from `data_in`=A5.
- `go` asserted while `busy`, and COUNT=1/TAG_IDX=0 → no restart; the single word push coincides with `start`, and `done` arrives 4 cycles after `go`.
